// File: rtl/pat_his_tab_if.sv
// Bus between the branch history table and the pattern history table:
// lookup and update requests in, registered prediction and sweep status out.
interface pat_his_tab_if #(
  parameter int HIST_W = 10
);
  logic              clr;
  logic              lk_en;
  logic [HIST_W-1:0] lk_hist;
  logic [HIST_W-1:0] lk_pc;
  logic              up_en;
  logic [HIST_W-1:0] up_hist;
  logic [HIST_W-1:0] up_pc;
  logic              up_taken;
  logic              pred_vld;
  logic              pred_taken;
  logic [1:0]        pred_cnt;
  logic              busy;

  // Requesting side (history table / branch unit)
  modport master (
    output clr, lk_en, lk_hist, lk_pc, up_en, up_hist, up_pc, up_taken,
    input  pred_vld, pred_taken, pred_cnt, busy
  );

  // Table side
  modport slave (
    input  clr, lk_en, lk_hist, lk_pc, up_en, up_hist, up_pc, up_taken,
    output pred_vld, pred_taken, pred_cnt, busy
  );
endinterface

// File: rtl/pat_his_tab.sv
// Pattern history table: one 2-bit saturating counter per history index.
// Lookups return a registered prediction one cycle after lk_en. Resolved
// branches go through a one-stage read-modify-write: captured on one edge,
// written on the next. Because the stage reads the array during the cycle
// after capture, a back-to-back update to the same entry already sees the
// previous commit, so no forwarding path is needed for updates. A lookup
// hitting the entry that commits on the same edge is bypassed to the new
// value. After reset or clr, a sweep rewrites every entry with INIT_CNT.
module pat_his_tab #(
  parameter int         HIST_W   = 10,
  parameter int         DEPTH    = 1 << HIST_W,
  parameter logic [1:0] INIT_CNT = 2'b01,
  parameter bit         USE_PC   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  pat_his_tab_if.slave  bus
);

  localparam logic [0:0]        ST_INIT  = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;
  localparam logic [HIST_W-1:0] PTR_LAST = HIST_W'(DEPTH - 1);

  // Sweep control
  logic [0:0]        r_state;
  logic [HIST_W-1:0] r_ptr;
  logic              r_busy;

  // Update stage register
  logic              r_up_vld;
  logic [HIST_W-1:0] r_up_idx;
  logic              r_up_taken;

  // Prediction output registers
  logic              r_pred_vld;
  logic [1:0]        r_pred_cnt;

  // Counter storage; not reset, the sweep initialises it
  logic [1:0]        r_tab [DEPTH];

  logic              w_run;
  logic              w_lk_acc;
  logic              w_commit;
  logic [HIST_W-1:0] w_lk_idx;
  logic [HIST_W-1:0] w_up_idx_in;
  logic [1:0]        w_up_cur;
  logic [1:0]        w_up_new;
  logic              w_we;
  logic [HIST_W-1:0] w_waddr;
  logic [1:0]        w_wdata;

  assign w_run       = (r_state == ST_RUN);
  assign w_lk_acc    = w_run & bus.lk_en;
  assign w_lk_idx    = bus.lk_hist ^ ({HIST_W{USE_PC}} & bus.lk_pc);
  assign w_up_idx_in = bus.up_hist ^ ({HIST_W{USE_PC}} & bus.up_pc);
  // A clr in RUN discards whatever sits in the update stage
  assign w_commit    = w_run & r_up_vld & ~bus.clr;
  assign w_up_cur    = r_tab[r_up_idx];

  // Saturating step of the staged counter (no wrap at either end)
  always_comb begin
    w_up_new = w_up_cur;
    if (r_up_taken) begin
      if (w_up_cur != 2'b11) w_up_new = w_up_cur + 2'd1;
    end else begin
      if (w_up_cur != 2'b00) w_up_new = w_up_cur - 2'd1;
    end
  end

  // Single array write port: sweep writes in INIT, staged update in RUN
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr;
    w_wdata = INIT_CNT;
    if (!reset) begin
      w_we = 1'b0;
    end else if (!w_run) begin
      w_we = 1'b1;
    end else if (w_commit) begin
      w_we    = 1'b1;
      w_waddr = r_up_idx;
      w_wdata = w_up_new;
    end
  end

  // Counter array write
  always_ff @(posedge clk) begin
    if (w_we) r_tab[w_waddr] <= w_wdata;
  end

  // Sweep FSM: INIT walks every entry, clr restarts from entry 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else if (!w_run) begin
      if (bus.clr) begin
        r_ptr <= '0;
      end else if (r_ptr == PTR_LAST) begin
        r_state <= ST_RUN;
        r_busy  <= 1'b0;
        r_ptr   <= '0;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end else if (bus.clr) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end
  end

  // Update stage capture; requests while busy or clearing are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_up_vld   <= 1'b0;
      r_up_idx   <= '0;
      r_up_taken <= 1'b0;
    end else begin
      r_up_vld   <= w_run & ~bus.clr & bus.up_en;
      r_up_idx   <= w_up_idx_in;
      r_up_taken <= bus.up_taken;
    end
  end

  // Registered lookup with bypass from the update committing on this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pred_vld <= 1'b0;
      r_pred_cnt <= 2'b00;
    end else begin
      r_pred_vld <= w_lk_acc;
      if (w_lk_acc) begin
        if (w_commit && (r_up_idx == w_lk_idx)) r_pred_cnt <= w_up_new;
        else                                    r_pred_cnt <= r_tab[w_lk_idx];
      end
    end
  end

  assign bus.pred_vld   = r_pred_vld;
  assign bus.pred_cnt   = r_pred_cnt;
  assign bus.pred_taken = r_pred_cnt[1];
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_pat_his_tab.sv
// Bench for pat_his_tab: reference model of the counter table, a vector table
// for the counter/bypass sequences, hand-written clr/reset sequences and a
// randomized phase over a small pool of colliding indices.
module tb_pat_his_tab;
  localparam int HW = 10;
  localparam int N  = 1024;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pat_his_tab_if #(.HIST_W(HW)) bus ();

  pat_his_tab #(
    .HIST_W(HW), .DEPTH(N), .INIT_CNT(2'b01), .USE_PC(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: plain array of counters, sweep countdown, pending update
  int m_tab [N];
  int m_sweep;
  bit m_pend;
  int m_pidx;
  bit m_ptaken;
  bit e_vld;
  int e_cnt;

  typedef struct {
    bit lk; int lh; int lp;
    bit up; int uh; int upc; bit ut;
    bit ev; int ec;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic model_reset();
    m_sweep = N;
    m_pend  = 1'b0;
    e_vld   = 1'b0;
    e_cnt   = 0;
    for (int i = 0; i < N; i++) m_tab[i] = 1;
  endtask

  // One clock: drive at negedge, advance model at the edge, compare at +1
  task automatic step(input bit clr, input bit lk, input int lh, input int lp,
                      input bit up, input int uh, input int upc, input bit ut);
    @(negedge clk);
    bus.clr      = clr;
    bus.lk_en    = lk;
    bus.lk_hist  = lh[HW-1:0];
    bus.lk_pc    = lp[HW-1:0];
    bus.up_en    = up;
    bus.up_hist  = uh[HW-1:0];
    bus.up_pc    = upc[HW-1:0];
    bus.up_taken = ut;
    @(posedge clk);
    #1;
    if (m_sweep > 0) begin
      if (clr) m_sweep = N;
      else     m_sweep--;
      e_vld  = 1'b0;
      m_pend = 1'b0;
    end else if (clr) begin
      m_sweep = N;
      m_pend  = 1'b0;
      e_vld   = 1'b0;
      for (int i = 0; i < N; i++) m_tab[i] = 1;
    end else begin
      if (m_pend) begin
        m_tab[m_pidx] = sat(m_tab[m_pidx], m_ptaken);
        m_pend = 1'b0;
      end
      e_vld = lk;
      if (lk) e_cnt = m_tab[(lh ^ lp) & (N - 1)];
      if (up) begin
        m_pend   = 1'b1;
        m_pidx   = (uh ^ upc) & (N - 1);
        m_ptaken = ut;
      end
    end
    check("busy", int'(bus.busy), (m_sweep > 0) ? 1 : 0);
    check("pred_vld", int'(bus.pred_vld), int'(e_vld));
    check("pred_cnt", int'(bus.pred_cnt), e_cnt);
    check("pred_taken", int'(bus.pred_taken), e_cnt / 2);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic lookup(input int idx, input int exp, input string name);
    step(1'b0, 1'b1, idx, 0, 1'b0, 0, 0, 1'b0);
    check(name, int'(bus.pred_cnt), exp);
    $display("lookup idx=%03h cnt=%0d", idx, bus.pred_cnt);
  endtask

  task automatic count_sweep(output int n);
    n = 0;
    while (bus.busy && n < 2000) begin
      idle();
      n++;
    end
  endtask

  function automatic int pick_idx();
    case ($urandom_range(0, 4))
      0: return 'h1AA;
      1: return 'h033;
      2: return 'h020;
      3: return 'h3FF;
      default: return int'($urandom_range(0, N - 1));
    endcase
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Counter sequences on idx 0x1AA (hist 0x155 ^ pc 0x0FF), then others
    vt[0]  = '{0, 0, 0,        1, 'h155, 'hFF, 1,  0, 0};
    vt[1]  = '{1, 'h155, 'hFF, 1, 'h155, 'hFF, 1,  1, 2};
    vt[2]  = '{1, 'h155, 'hFF, 1, 'h155, 'hFF, 1,  1, 3};
    vt[3]  = '{1, 'h155, 'hFF, 1, 'h155, 'hFF, 1,  1, 3};
    vt[4]  = '{1, 'h155, 'hFF, 1, 'h155, 'hFF, 0,  1, 3};
    vt[5]  = '{1, 'h155, 'hFF, 1, 'h155, 'hFF, 0,  1, 2};
    vt[6]  = '{1, 'h155, 'hFF, 1, 'h155, 'hFF, 0,  1, 1};
    vt[7]  = '{1, 'h155, 'hFF, 1, 'h155, 'hFF, 0,  1, 0};
    vt[8]  = '{1, 'h155, 'hFF, 1, 'h155, 'hFF, 0,  1, 0};
    vt[9]  = '{1, 'h155, 'hFF, 0, 0, 0, 0,         1, 0};
    vt[10] = '{1, 'h1AA, 0,    0, 0, 0, 0,         1, 0};
    vt[11] = '{0, 0, 0,        0, 0, 0, 0,         0, 0};
    vt[12] = '{0, 0, 0,        1, 'h033, 0, 1,     0, 0};
    vt[13] = '{0, 0, 0,        1, 'h033, 0, 1,     0, 0};
    vt[14] = '{0, 0, 0,        1, 'h033, 0, 0,     0, 0};
    vt[15] = '{0, 0, 0,        0, 0, 0, 0,         0, 0};
    vt[16] = '{1, 'h033, 0,    0, 0, 0, 0,         1, 2};
    vt[17] = '{1, 'h1AA, 0,    1, 'h100, 0, 1,     1, 0};
    vt[18] = '{1, 'h100, 0,    0, 0, 0, 0,         1, 2};
    vt[19] = '{0, 0, 0,        1, 'h020, 0, 1,     0, 0};
    vt[20] = '{1, 'h020, 0,    0, 0, 0, 0,         1, 2};
    vt[21] = '{1, 0, 'h020,    0, 0, 0, 0,         1, 2};

    bus.clr = 1'b0; bus.lk_en = 1'b0; bus.lk_hist = '0; bus.lk_pc = '0;
    bus.up_en = 1'b0; bus.up_hist = '0; bus.up_pc = '0; bus.up_taken = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 1);
    check("rst_vld", int'(bus.pred_vld), 0);
    check("rst_cnt", int'(bus.pred_cnt), 0);
    check("rst_taken", int'(bus.pred_taken), 0);
    #1 reset = 1'b1;

    // Sweep with lookups held on: ignored for N cycles
    for (int i = 0; i < N; i++)
      step(1'b0, 1'b1, int'($urandom_range(0, N - 1)), 0, 1'b1, i, 0, 1'b1);
    check("sweep_done", int'(bus.busy), 0);
    $display("sweep after reset complete busy=%0b", bus.busy);
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, i, 0, 1'b0, 0, 0, 1'b0);
    $display("all %0d entries looked up after sweep", N);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      step(1'b0, vt[i].lk, vt[i].lh, vt[i].lp, vt[i].up, vt[i].uh, vt[i].upc, vt[i].ut);
      check("vec_vld", int'(bus.pred_vld), int'(vt[i].ev));
      if (vt[i].ev) check("vec_cnt", int'(bus.pred_cnt), vt[i].ec);
      $display("vec %0d lk=%0b up=%0b taken=%0b vld=%0b cnt=%0d", i, vt[i].lk,
               vt[i].up, vt[i].ut, bus.pred_vld, bus.pred_cnt);
    end

    // clr in RUN with an update pending, then clr again mid-sweep
    step(1'b0, 1'b0, 0, 0, 1'b1, 'h020, 0, 1'b1);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    check("clr_busy", int'(bus.busy), 1);
    repeat (100) idle();
    step(1'b1, 1'b0, 0, 0, 1'b1, 'h020, 0, 1'b1);
    count_sweep(n);
    check("clr_restart_len", n, N);
    $display("clr sweep length=%0d", n);
    lookup('h020, 1, "clr_020");
    lookup('h1AA, 1, "clr_1aa");
    lookup('h033, 1, "clr_033");
    lookup('h100, 1, "clr_100");

    // Randomized traffic over a colliding index pool
    for (int i = 0; i < 400; i++) begin
      automatic bit lk  = 1'($urandom_range(0, 1));
      automatic bit up  = 1'($urandom_range(0, 1));
      automatic bit ut  = 1'($urandom_range(0, 1));
      automatic int lp  = int'($urandom_range(0, N - 1));
      automatic int upc = int'($urandom_range(0, N - 1));
      automatic int lh  = pick_idx() ^ lp;
      automatic int uh  = pick_idx() ^ upc;
      step(1'b0, lk, lh, lp, up, uh, upc, ut);
      $display("rnd %0d lk=%0b idx=%03h up=%0b uidx=%03h t=%0b vld=%0b cnt=%0d", i, lk,
               (lh ^ lp) & (N - 1), up, (uh ^ upc) & (N - 1), ut, bus.pred_vld, bus.pred_cnt);
    end

    // Async reset while a valid prediction is showing
    step(1'b0, 1'b0, 0, 0, 1'b1, 'h3FF, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1, 'h3FF, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1, 'h3FF, 0, 1'b1);
    step(1'b0, 1'b1, 'h3FF, 0, 1'b0, 0, 0, 1'b0);
    check("pre_rst_vld", int'(bus.pred_vld), 1);
    check("pre_rst_cnt", int'(bus.pred_cnt), 3);
    #2 reset = 1'b0;
    #1;
    check("async_vld", int'(bus.pred_vld), 0);
    check("async_cnt", int'(bus.pred_cnt), 0);
    check("async_taken", int'(bus.pred_taken), 0);
    check("async_busy", int'(bus.busy), 1);
    $display("async reset in RUN: vld=%0b cnt=%0d busy=%0b", bus.pred_vld, bus.pred_cnt, bus.busy);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Reset again mid-sweep at ptr 0x200; sweep must restart from 0
    repeat ('h200) idle();
    #2 reset = 1'b0;
    #1;
    check("midsweep_busy", int'(bus.busy), 1);
    check("midsweep_vld", int'(bus.pred_vld), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    count_sweep(n);
    check("midsweep_len", n, N);
    $display("sweep after mid-sweep reset length=%0d", n);
    lookup('h3FF, 1, "post_rst_3ff");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
